// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the two-requester DDR AXI arbiter and the DDR test logic.
package ddr_axi_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 128;

    localparam logic [31:0] DDR_BASE = 32'h8f00_0000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ddr_axi_arb2_rr_arb2.sv
// Two-input round-robin picker: prio breaks a tie, otherwise the lone requester wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_idx
);

    assign gnt_idx = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/ddr_axi_arb2.sv
// Shares one DDR AXI port between two requesters; write and read paths are
// arbitrated independently and a grant is held for the whole burst.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; grant on the next edge if ddr_ready and a request
// ADDR   | owner's AW/AR channel passed through until its handshake
// DATA   | owner's W/R channel passed through until the last-beat handshake
module ddr_axi_arb2
    import ddr_axi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ddr_ready,

    input  logic [2*ADDR_W-1:0]     m_awaddr,
    input  logic [15:0]             m_awlen,
    input  logic [1:0]              m_awvalid,
    output logic [1:0]              m_awready,

    input  logic [2*DATA_W-1:0]     m_wdata,
    input  logic [2*DATA_W/8-1:0]   m_wstrb,
    input  logic [1:0]              m_wlast,
    input  logic [1:0]              m_wvalid,
    output logic [1:0]              m_wready,

    input  logic [2*ADDR_W-1:0]     m_araddr,
    input  logic [15:0]             m_arlen,
    input  logic [1:0]              m_arvalid,
    output logic [1:0]              m_arready,

    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_rlast,
    output logic [1:0]              m_rvalid,
    input  logic [1:0]              m_rready,

    output logic [ADDR_W-1:0]       s_awaddr,
    output logic [7:0]              s_awlen,
    output logic                    s_awvalid,
    input  logic                    s_awready,

    output logic [DATA_W-1:0]       s_wdata,
    output logic [DATA_W/8-1:0]     s_wstrb,
    output logic                    s_wlast,
    output logic                    s_wvalid,
    input  logic                    s_wready,

    output logic [ADDR_W-1:0]       s_araddr,
    output logic [7:0]              s_arlen,
    output logic                    s_arvalid,
    input  logic                    s_arready,

    input  logic [DATA_W-1:0]       s_rdata,
    input  logic                    s_rlast,
    input  logic                    s_rvalid,
    output logic                    s_rready
);

    localparam int STRB_W = DATA_W / 8;

    wr_state_t wstate;
    rd_state_t rstate;
    logic      wgnt, wprio, wsel;
    logic      rgnt, rprio, rsel;
    logic      aw_pass, w_pass, ar_pass, r_pass;

    rr_arb2 u_wr_arb (.req(m_awvalid), .prio(wprio), .gnt_idx(wsel));
    rr_arb2 u_rd_arb (.req(m_arvalid), .prio(rprio), .gnt_idx(rsel));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate <= W_IDLE;
            wgnt   <= 1'b0;
            wprio  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (ddr_ready && |m_awvalid) begin
                    wgnt   <= wsel;
                    wstate <= W_ADDR;
                end
                W_ADDR: if (s_awvalid && s_awready) wstate <= W_DATA;
                W_DATA: if (s_wvalid && s_wready && s_wlast) begin
                    wstate <= W_IDLE;
                    wprio  <= ~wgnt;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate <= R_IDLE;
            rgnt   <= 1'b0;
            rprio  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: if (ddr_ready && |m_arvalid) begin
                    rgnt   <= rsel;
                    rstate <= R_ADDR;
                end
                R_ADDR: if (s_arvalid && s_arready) rstate <= R_DATA;
                R_DATA: if (s_rvalid && s_rready && s_rlast) begin
                    rstate <= R_IDLE;
                    rprio  <= ~rgnt;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Data/address muxes follow the registered grant even when idle, so a
    // reset port shows requester 0; only valid/ready are gated by state.
    assign s_awaddr  = wgnt ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    assign s_awlen   = wgnt ? m_awlen[15:8] : m_awlen[7:0];
    assign s_awvalid = (wstate == W_ADDR) && m_awvalid[wgnt];
    assign aw_pass   = (wstate == W_ADDR) && s_awready;
    assign m_awready = {aw_pass & wgnt, aw_pass & ~wgnt};

    assign s_wdata   = wgnt ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    assign s_wstrb   = wgnt ? m_wstrb[2*STRB_W-1:STRB_W] : m_wstrb[STRB_W-1:0];
    assign s_wlast   = m_wlast[wgnt];
    assign s_wvalid  = (wstate == W_DATA) && m_wvalid[wgnt];
    assign w_pass    = (wstate == W_DATA) && s_wready;
    assign m_wready  = {w_pass & wgnt, w_pass & ~wgnt};

    assign s_araddr  = rgnt ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
    assign s_arlen   = rgnt ? m_arlen[15:8] : m_arlen[7:0];
    assign s_arvalid = (rstate == R_ADDR) && m_arvalid[rgnt];
    assign ar_pass   = (rstate == R_ADDR) && s_arready;
    assign m_arready = {ar_pass & rgnt, ar_pass & ~rgnt};

    assign m_rdata   = s_rdata;
    assign m_rlast   = s_rlast;
    assign r_pass    = (rstate == R_DATA) && s_rvalid;
    assign m_rvalid  = {r_pass & rgnt, r_pass & ~rgnt};
    assign s_rready  = (rstate == R_DATA) && m_rready[rgnt];

endmodule

// File: tb/tb_ddr_axi_arb2.sv
// Self-checking bench for ddr_axi_arb2: directed scenarios plus a randomized
// round-robin write run checked against a transaction-level model.
module tb_ddr_axi_arb2;
    import ddr_axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rstn, ddr_ready;
    logic [2*AW-1:0] m_awaddr;  logic [15:0] m_awlen;  logic [1:0] m_awvalid, m_awready;
    logic [2*DW-1:0] m_wdata;   logic [2*SW-1:0] m_wstrb;
    logic [1:0]      m_wlast, m_wvalid, m_wready;
    logic [2*AW-1:0] m_araddr;  logic [15:0] m_arlen;  logic [1:0] m_arvalid, m_arready;
    logic [DW-1:0]   m_rdata;   logic m_rlast;         logic [1:0] m_rvalid, m_rready;
    logic [AW-1:0]   s_awaddr;  logic [7:0] s_awlen;   logic s_awvalid, s_awready;
    logic [DW-1:0]   s_wdata;   logic [SW-1:0] s_wstrb;
    logic            s_wlast, s_wvalid, s_wready;
    logic [AW-1:0]   s_araddr;  logic [7:0] s_arlen;   logic s_arvalid, s_arready;
    logic [DW-1:0]   s_rdata;   logic s_rlast, s_rvalid, s_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_axi_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn), .ddr_ready(ddr_ready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        m_awaddr = '0; m_awlen = '0; m_awvalid = '0;
        m_wdata = '0;  m_wstrb = '0; m_wlast = '0; m_wvalid = '0;
        m_araddr = '0; m_arlen = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
        s_rdata = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        ddr_ready = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0; ddr_ready = 1'b0;
        m_awaddr = {$urandom, $urandom}; m_araddr = {$urandom, $urandom};
        m_wdata = {rnd128(), rnd128()};  m_wstrb = {$urandom, $urandom};
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_arvalid = 2'b11; m_rready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1;
        #1;
        checks++;
        if ({s_awvalid, s_wvalid, s_arvalid, s_rready} !== 4'b0000) begin
            errors++; $display("FAIL reset_s_handshake: got %b expected 0000",
                               {s_awvalid, s_wvalid, s_arvalid, s_rready});
        end
        checks++;
        if ({m_awready, m_wready, m_arready, m_rvalid} !== 8'h00) begin
            errors++; $display("FAIL reset_m_handshake: got %h expected 00",
                               {m_awready, m_wready, m_arready, m_rvalid});
        end
        checks++;
        if (s_awaddr !== m_awaddr[AW-1:0] || s_araddr !== m_araddr[AW-1:0]) begin
            errors++; $display("FAIL reset_addr_mux: got %h/%h expected %h/%h",
                               s_awaddr, s_araddr, m_awaddr[AW-1:0], m_araddr[AW-1:0]);
        end
        checks++;
        if (s_wdata !== m_wdata[DW-1:0] || s_wstrb !== m_wstrb[SW-1:0]) begin
            errors++; $display("FAIL reset_wdata_mux: got %h expected %h", s_wdata, m_wdata[DW-1:0]);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({s_awvalid, s_arvalid, m_awready, m_arready} !== 6'b0) begin
            errors++; $display("FAIL reset_gated_idle: got %b expected 000000",
                               {s_awvalid, s_arvalid, m_awready, m_arready});
        end
        idle_inputs();
    endtask

    task automatic test_ddr_gate();
        logic [AW-1:0] a0;
        a0 = DDR_BASE + 32'h4;
        do_reset();
        ddr_ready = 1'b0;
        m_awvalid = 2'b01; m_awaddr[AW-1:0] = a0; m_awlen = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            checks++;
            if (s_awvalid !== 1'b0 || m_awready !== 2'b00) begin
                errors++; $display("FAIL gate_no_grant: cycle %0d got awvalid %b expected 0", k, s_awvalid);
            end
        end
        ddr_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (s_awvalid !== 1'b1 || s_awaddr !== 32'h8f00_0004) begin
            errors++; $display("FAIL gate_release: got valid %b addr %h expected 1 8f000004",
                               s_awvalid, s_awaddr);
        end
    endtask

    // Both requesters always busy: grants must alternate, each burst
    // followed by exactly one idle bubble, under random slave backpressure.
    task automatic test_write_rr();
        logic [AW-1:0] addr[2];
        logic [7:0]    len[2], beat[2];
        logic [DW-1:0] data[2];
        logic [SW-1:0] strb[2];
        logic          awd[2];
        logic          eg, exp_awv;
        logic [1:0]    exp_awr, exp_wr, awhs, whs;
        int            since, ndone, cyc;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            addr[i] = DDR_BASE | $urandom_range(0, 32'hffff); len[i] = 8'($urandom_range(0, 3));
            data[i] = rnd128(); strb[i] = 16'($urandom); beat[i] = '0; awd[i] = 1'b0;
        end
        eg = 1'b0; since = 0; ndone = 0; cyc = 0;
        while (ndone < 24 && cyc < 2000) begin
            @(negedge clk); cyc++;
            s_awready = 1'($urandom_range(0, 1));
            s_wready  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                m_awvalid[i] = !awd[i];
                m_awaddr[i*AW +: AW] = addr[i];
                m_awlen[i*8 +: 8] = len[i];
                m_wvalid[i] = 1'b1;
                m_wdata[i*DW +: DW] = data[i] ^ DW'(beat[i]);
                m_wstrb[i*SW +: SW] = strb[i];
                m_wlast[i] = (beat[i] == len[i]);
            end
            #1;
            exp_awv = (since >= 1) && !awd[eg];
            exp_awr = (exp_awv && s_awready) ? (eg ? 2'b10 : 2'b01) : 2'b00;
            exp_wr  = (awd[eg] && s_wready) ? (eg ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (s_awvalid !== exp_awv || m_awready !== exp_awr) begin
                errors++; $display("FAIL rr_aw: got valid %b ready %b expected %b %b (owner %0d)",
                                   s_awvalid, m_awready, exp_awv, exp_awr, eg);
            end
            checks++;
            if (s_wvalid !== awd[eg] || m_wready !== exp_wr) begin
                errors++; $display("FAIL rr_w_hs: got valid %b ready %b expected %b %b",
                                   s_wvalid, m_wready, awd[eg], exp_wr);
            end
            if (exp_awv) begin
                checks++;
                if (s_awaddr !== addr[eg] || s_awlen !== len[eg]) begin
                    errors++; $display("FAIL rr_aw_payload: got %h/%0d expected %h/%0d",
                                       s_awaddr, s_awlen, addr[eg], len[eg]);
                end
            end
            if (awd[eg]) begin
                checks++;
                if (s_wdata !== (data[eg] ^ DW'(beat[eg])) || s_wstrb !== strb[eg] ||
                    s_wlast !== (beat[eg] == len[eg])) begin
                    errors++; $display("FAIL rr_w_payload: got %h/%h/%b expected %h/%h",
                                       s_wdata, s_wstrb, s_wlast, data[eg] ^ DW'(beat[eg]), strb[eg]);
                end
            end
            awhs = m_awready & m_awvalid;
            whs  = m_wready & m_wvalid;
            @(posedge clk);
            since++;
            for (int i = 0; i < 2; i++) begin
                if (awhs[i]) awd[i] = 1'b1;
                if (whs[i]) begin
                    if (beat[i] == len[i]) begin
                        ndone++; since = 0; eg = ~eg;
                        addr[i] = DDR_BASE | $urandom_range(0, 32'hffff);
                        len[i] = 8'($urandom_range(0, 3));
                        data[i] = rnd128(); strb[i] = 16'($urandom);
                        beat[i] = '0; awd[i] = 1'b0;
                    end else begin
                        beat[i] = beat[i] + 8'd1;
                    end
                end
            end
        end
        checks++;
        if (ndone != 24) begin
            errors++; $display("FAIL rr_timeout: got %0d bursts expected 24", ndone);
        end
        idle_inputs();
    endtask

    task automatic test_burst_lock();
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d1;
        logic [7:0]    beat;
        logic          hs;
        int            cyc;
        a0 = DDR_BASE | 32'h100; a1 = DDR_BASE | 32'h200; d1 = rnd128();
        do_reset();
        @(negedge clk);
        m_awvalid = 2'b10; m_awaddr[AW +: AW] = a1; m_awlen[15:8] = 8'd3; s_awready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (s_awvalid !== 1'b1 || s_awaddr !== a1) begin
            errors++; $display("FAIL lock_grant1: got %b %h expected 1 %h", s_awvalid, s_awaddr, a1);
        end
        m_awvalid = 2'b11; m_awaddr[AW-1:0] = a0; m_awlen[7:0] = 8'd0; s_awready = 1'b1;
        #1;
        checks++;
        if (m_awready !== 2'b10) begin
            errors++; $display("FAIL lock_awready: got %b expected 10", m_awready);
        end
        @(negedge clk);
        m_awvalid = 2'b01;
        beat = '0; cyc = 0;
        while (beat < 8'd4 && cyc < 50) begin
            m_wvalid = 2'b10;
            m_wdata[DW +: DW] = d1 ^ DW'(beat);
            m_wlast = (beat == 8'd3) ? 2'b10 : 2'b00;
            s_wready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (m_awready !== 2'b00 || s_awvalid !== 1'b0 || s_wdata !== (d1 ^ DW'(beat)) ||
                m_wready !== (s_wready ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL lock_burst: beat %0d awready %b awvalid %b wready %b",
                                   beat, m_awready, s_awvalid, m_wready);
            end
            hs = m_wready[1];
            @(posedge clk);
            if (hs) beat = beat + 8'd1;
            @(negedge clk);
            cyc++;
        end
        m_wvalid = 2'b00; m_wlast = 2'b00;
        checks++;
        if (beat != 8'd4) begin
            errors++; $display("FAIL lock_timeout: got %0d beats expected 4", beat);
        end
        #1;
        checks++;
        if (s_awvalid !== 1'b0 || m_awready !== 2'b00) begin
            errors++; $display("FAIL lock_bubble: got %b %b expected 0 00", s_awvalid, m_awready);
        end
        @(negedge clk); #1;
        checks++;
        if (s_awvalid !== 1'b1 || s_awaddr !== a0 || m_awready !== 2'b01) begin
            errors++; $display("FAIL lock_next: got %b %h %b expected 1 %h 01",
                               s_awvalid, s_awaddr, m_awready, a0);
        end
        idle_inputs();
    endtask

    task automatic test_read_hold();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = DDR_BASE | 32'h40; d = rnd128();
        do_reset();
        @(negedge clk);
        m_arvalid = 2'b01; m_araddr[AW-1:0] = a; m_arlen = '0; s_arready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== a || m_arready !== 2'b01) begin
            errors++; $display("FAIL rd_addr: got %b %h %b expected 1 %h 01", s_arvalid, s_araddr, m_arready, a);
        end
        @(negedge clk);
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = d; s_rlast = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m_rready = {1'($urandom_range(0, 1)), 1'b0};
            #1;
            checks++;
            if (s_rready !== 1'b0 || m_rvalid !== 2'b01 || m_rdata !== d || m_rlast !== 1'b1) begin
                errors++; $display("FAIL rd_hold: cycle %0d got rready %b rvalid %b expected 0 01",
                                   k, s_rready, m_rvalid);
            end
            @(negedge clk);
        end
        m_rready = 2'b01;
        #1;
        checks++;
        if (s_rready !== 1'b1) begin
            errors++; $display("FAIL rd_accept: got %b expected 1", s_rready);
        end
        @(negedge clk); #1;
        checks++;
        if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
            errors++; $display("FAIL rd_done: got %b %b expected 00 0", m_rvalid, s_rready);
        end
        idle_inputs();
    endtask

    // With every ready high, a burst of len L finishes on edge L+3 after
    // the request is driven, regardless of traffic in the other direction.
    task automatic test_concurrent();
        logic [7:0]    lw, lr, wb, rb;
        logic [DW-1:0] dw, dr;
        logic          awd, ard, wfin, rfin, whs, rhs, awhs, arhs;
        int            cyc, wcyc, rcyc;
        do_reset();
        for (int rep = 0; rep < 3; rep++) begin
            lw = 8'($urandom_range(0, 7)); lr = 8'($urandom_range(0, 7));
            dw = rnd128(); dr = rnd128();
            wb = '0; rb = '0; awd = 1'b0; ard = 1'b0; wfin = 1'b0; rfin = 1'b0;
            cyc = 0; wcyc = -1; rcyc = -1;
            m_awaddr[AW-1:0] = DDR_BASE | $urandom_range(0, 32'hfff); m_awlen[7:0] = lw;
            m_araddr[AW +: AW] = DDR_BASE | $urandom_range(0, 32'hfff); m_arlen[15:8] = lr;
            s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
            while (!(wfin && rfin) && cyc < 40) begin
                @(negedge clk);
                m_awvalid = {1'b0, !awd && !wfin};
                m_wvalid  = {1'b0, !wfin};
                m_wdata[DW-1:0] = dw ^ DW'(wb);
                m_wlast   = {1'b0, wb == lw};
                m_arvalid = {!ard && !rfin, 1'b0};
                m_rready  = 2'b10;
                s_rvalid  = ard && !rfin;
                s_rdata   = dr ^ DW'(rb);
                s_rlast   = (rb == lr);
                #1;
                if (s_wvalid) begin
                    checks++;
                    if (s_wdata !== (dw ^ DW'(wb))) begin
                        errors++; $display("FAIL conc_wdata: got %h expected %h", s_wdata, dw ^ DW'(wb));
                    end
                end
                awhs = m_awready[0] & m_awvalid[0]; whs = m_wready[0] & m_wvalid[0];
                arhs = m_arready[1] & m_arvalid[1]; rhs = s_rready & s_rvalid;
                @(posedge clk);
                cyc++;
                if (awhs) awd = 1'b1;
                if (arhs) ard = 1'b1;
                if (whs) begin
                    if (wb == lw) begin wfin = 1'b1; wcyc = cyc; end
                    else wb = wb + 8'd1;
                end
                if (rhs) begin
                    if (rb == lr) begin rfin = 1'b1; rcyc = cyc; end
                    else rb = rb + 8'd1;
                end
            end
            checks++;
            if (wcyc != int'(lw) + 3 || rcyc != int'(lr) + 3) begin
                errors++; $display("FAIL conc_latency: got w %0d r %0d expected w %0d r %0d",
                                   wcyc, rcyc, int'(lw) + 3, int'(lr) + 3);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] a0, a1, a0n;
        a0 = DDR_BASE | 32'h10; a1 = DDR_BASE | 32'h20; a0n = DDR_BASE | 32'h30;
        do_reset();
        s_awready = 1'b1; s_wready = 1'b1;
        @(negedge clk);
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_wlast = 2'b01; m_awaddr[AW-1:0] = a0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (m_wready !== 2'b01) begin
            errors++; $display("FAIL rst_prep_write: got %b expected 01", m_wready);
        end
        @(negedge clk);
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_wlast = 2'b00;
        m_awaddr[AW +: AW] = a1; m_awlen = {8'd3, 8'd0};
        @(negedge clk);
        @(negedge clk);
        m_awvalid = 2'b00;
        @(negedge clk);
        m_awvalid = 2'b11; m_awaddr[AW-1:0] = a0n;
        #1;
        checks++;
        if (s_wvalid !== 1'b1 || m_wready !== 2'b10) begin
            errors++; $display("FAIL rst_in_burst: got %b %b expected 1 10", s_wvalid, m_wready);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (s_wvalid !== 1'b0 || m_wready !== 2'b00 || s_awvalid !== 1'b0) begin
            errors++; $display("FAIL rst_async: got wvalid %b wready %b awvalid %b expected 0 00 0",
                               s_wvalid, m_wready, s_awvalid);
        end
        @(negedge clk);
        rstn = 1'b1; m_wvalid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (s_awvalid !== 1'b1 || s_awaddr !== a0n) begin
            errors++; $display("FAIL rst_first_grant: got %b %h expected 1 %h", s_awvalid, s_awaddr, a0n);
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        ddr_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_ddr_gate();
        test_write_rr();
        test_burst_lock();
        test_read_hold();
        test_concurrent();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
